// File: rtl/ex_stage_unit_if.sv
// ID/EX input bundle and EX/MEM output slot of the execute stage,
// grouped so the stage can be dropped between pipeline registers.
interface ex_stage_unit_if #(
  parameter int XLEN = 32
);
  // ID/EX side
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src_data_a_in;
  logic [XLEN-1:0] src_data_b_in;
  logic [XLEN-1:0] imm_value_in;
  logic            alu_src_imm_in;
  logic [4:0]      dest_reg_in;
  logic [XLEN-1:0] pc_input;
  logic [3:0]      ex_control_in;
  logic            reg_write_en_in;
  logic            mem_write_en_in;
  logic            memory_enable_in;

  // EX/MEM side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result_out;
  logic [XLEN-1:0] store_data_out;
  logic [4:0]      dest_reg_out;
  logic [XLEN-1:0] pc_out;
  logic            reg_write_en_out;
  logic            mem_write_en_out;
  logic            memory_enable_out;
  logic            busy;

  // Execute stage view
  modport slave (
    input  in_valid, src_data_a_in, src_data_b_in, imm_value_in, alu_src_imm_in,
           dest_reg_in, pc_input, ex_control_in, reg_write_en_in,
           mem_write_en_in, memory_enable_in, out_ready,
    output in_ready, out_valid, alu_result_out, store_data_out, dest_reg_out,
           pc_out, reg_write_en_out, mem_write_en_out, memory_enable_out, busy
  );

  // Surrounding pipeline view
  modport master (
    output in_valid, src_data_a_in, src_data_b_in, imm_value_in, alu_src_imm_in,
           dest_reg_in, pc_input, ex_control_in, reg_write_en_in,
           mem_write_en_in, memory_enable_in, out_ready,
    input  in_ready, out_valid, alu_result_out, store_data_out, dest_reg_out,
           pc_out, reg_write_en_out, mem_write_en_out, memory_enable_out, busy
  );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier,
// feeding a one-entry registered EX/MEM output slot.
module ex_stage_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  ex_stage_unit_if.slave bus
);
  localparam int CNT_W = $clog2(MUL_CYCLES);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;

  state_t            state, next_state;
  logic [XLEN-1:0]   op_b, alu_res;
  logic [4:0]        shamt;
  logic              slot_free, accept, is_mul, load_alu, load_mul;

  logic [XLEN-1:0]   mcand, mplier, acc;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mul_store, mul_pc;
  logic [4:0]        mul_rd;
  logic              mul_rwe, mul_mwe, mul_men;

  assign op_b      = bus.alu_src_imm_in ? bus.imm_value_in : bus.src_data_b_in;
  assign shamt     = op_b[4:0];
  assign is_mul    = (bus.ex_control_in == OP_MUL);
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == IDLE) && slot_free && !flush;
  assign accept    = bus.in_valid && bus.in_ready;
  assign load_alu  = accept && !is_mul;
  assign load_mul  = (state == MUL_DONE) && slot_free && !flush;
  assign bus.busy  = (state != IDLE);

  // Single-cycle ALU result for every non-multiply op
  always_comb begin
    alu_res = '0;
    case (bus.ex_control_in)
      OP_ADD:  alu_res = bus.src_data_a_in + op_b;
      OP_SUB:  alu_res = bus.src_data_a_in - op_b;
      OP_AND:  alu_res = bus.src_data_a_in & op_b;
      OP_OR:   alu_res = bus.src_data_a_in | op_b;
      OP_XOR:  alu_res = bus.src_data_a_in ^ op_b;
      OP_SLL:  alu_res = bus.src_data_a_in << shamt;
      OP_SRL:  alu_res = bus.src_data_a_in >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.src_data_a_in) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.src_data_a_in) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.src_data_a_in < op_b};
      OP_PASS: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Multiplier FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Multiplier FSM next-state; flush overrides every transition
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (accept && is_mul) next_state = MUL_RUN;
        MUL_RUN:  if (cnt == CNT_W'(MUL_CYCLES - 1)) next_state = MUL_DONE;
        MUL_DONE: if (slot_free) next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Shift-add datapath: one partial product per MUL_RUN edge, fields held for retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0; mplier <= '0; acc <= '0; cnt <= '0;
      mul_store <= '0; mul_pc <= '0; mul_rd <= '0;
      mul_rwe <= 1'b0; mul_mwe <= 1'b0; mul_men <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept && is_mul) begin
      mcand     <= bus.src_data_a_in;
      mplier    <= op_b;
      acc       <= '0;
      cnt       <= '0;
      mul_store <= bus.src_data_b_in;
      mul_pc    <= bus.pc_input;
      mul_rd    <= bus.dest_reg_in;
      mul_rwe   <= bus.reg_write_en_in && (bus.dest_reg_in != 5'd0);
      mul_mwe   <= bus.mem_write_en_in;
      mul_men   <= bus.memory_enable_in;
    end else if (state == MUL_RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // EX/MEM slot: load from ALU or finished multiply, otherwise drain on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.alu_result_out <= '0; bus.store_data_out <= '0;
      bus.dest_reg_out <= '0;   bus.pc_out <= '0;
      bus.reg_write_en_out <= 1'b0; bus.mem_write_en_out <= 1'b0;
      bus.memory_enable_out <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
      bus.reg_write_en_out <= 1'b0; bus.mem_write_en_out <= 1'b0;
      bus.memory_enable_out <= 1'b0;
    end else if (load_alu) begin
      bus.out_valid         <= 1'b1;
      bus.alu_result_out    <= alu_res;
      bus.store_data_out    <= bus.src_data_b_in;
      bus.dest_reg_out      <= bus.dest_reg_in;
      bus.pc_out            <= bus.pc_input;
      bus.reg_write_en_out  <= bus.reg_write_en_in && (bus.dest_reg_in != 5'd0);
      bus.mem_write_en_out  <= bus.mem_write_en_in;
      bus.memory_enable_out <= bus.memory_enable_in;
    end else if (load_mul) begin
      bus.out_valid         <= 1'b1;
      bus.alu_result_out    <= acc;
      bus.store_data_out    <= mul_store;
      bus.dest_reg_out      <= mul_rd;
      bus.pc_out            <= mul_pc;
      bus.reg_write_en_out  <= mul_rwe;
      bus.mem_write_en_out  <= mul_mwe;
      bus.memory_enable_out <= mul_men;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage_unit.sv
// Bench for ex_stage_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_ex_stage_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_stage_unit_if #(.XLEN(32)) bus ();

  ex_stage_unit #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res, sd, pc;
    logic [4:0]  rd;
    logic        rwe, mwe, men;
  } slot_t;

  // Model state: the visible slot plus an in-flight multiply with its age in edges
  slot_t m_slot, m_mul;
  bit    m_valid, m_pend, m_zero, m_enz;
  int    m_age;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic slot_t make_slot();
    slot_t s;
    logic [31:0] a, b;
    a = bus.src_data_a_in;
    b = bus.alu_src_imm_in ? bus.imm_value_in : bus.src_data_b_in;
    case (bus.ex_control_in)
      4'd0:    s.res = a + b;
      4'd1:    s.res = a - b;
      4'd2:    s.res = a & b;
      4'd3:    s.res = a | b;
      4'd4:    s.res = a ^ b;
      4'd5:    s.res = a << b[4:0];
      4'd6:    s.res = a >> b[4:0];
      4'd7:    s.res = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    s.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    s.res = (a < b) ? 32'd1 : 32'd0;
      4'd10:   s.res = b;
      4'd11:   s.res = a * b;
      default: s.res = 32'd0;
    endcase
    s.sd  = bus.src_data_b_in;
    s.pc  = bus.pc_input;
    s.rd  = bus.dest_reg_in;
    s.rwe = bus.reg_write_en_in && (bus.dest_reg_in != 5'd0);
    s.mwe = bus.mem_write_en_in;
    s.men = bus.memory_enable_in;
    return s;
  endfunction

  // Transaction model, advanced on each active edge from the inputs that were presented
  always @(posedge clk or negedge rst_n) begin
    bit free, loaded;
    slot_t s;
    if (!rst_n) begin
      m_slot = '{default: '0};
      m_valid = 0; m_pend = 0; m_age = 0; m_zero = 1; m_enz = 1;
    end else begin
      free = !m_valid || bus.out_ready;
      if (flush) begin
        m_valid = 0; m_pend = 0;
        m_slot.rwe = 0; m_slot.mwe = 0; m_slot.men = 0;
        m_enz = 1;
      end else begin
        loaded = 0;
        if (m_pend) begin
          m_age++;
          if (m_age >= 33 && free) begin
            m_slot = m_mul; m_pend = 0; loaded = 1;
          end
        end else if (bus.in_valid && free) begin
          s = make_slot();
          if (bus.ex_control_in == 4'd11) begin
            m_mul = s; m_pend = 1; m_age = 0;
          end else begin
            m_slot = s; loaded = 1;
          end
        end
        if (loaded) begin
          m_valid = 1; m_zero = 0; m_enz = 0;
        end else if (bus.out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  // Compare process: every falling edge, outputs against the model
  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(!m_pend && (!m_valid || bus.out_ready) && !flush));
    chk("busy", 32'(bus.busy), 32'(m_pend));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid || m_zero) begin
      chk("alu_result", bus.alu_result_out, m_slot.res);
      chk("store_data", bus.store_data_out, m_slot.sd);
      chk("dest_reg", 32'(bus.dest_reg_out), 32'(m_slot.rd));
      chk("pc", bus.pc_out, m_slot.pc);
    end
    if (m_valid || m_zero || m_enz) begin
      chk("reg_we", 32'(bus.reg_write_en_out), 32'(m_slot.rwe));
      chk("mem_we", 32'(bus.mem_write_en_out), 32'(m_slot.mwe));
      chk("mem_en", 32'(bus.memory_enable_out), 32'(m_slot.men));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic sel, input logic [4:0] rd,
                       input logic we);
    bus.in_valid         = 1'b1;
    bus.ex_control_in    = op;
    bus.src_data_a_in    = a;
    bus.src_data_b_in    = b;
    bus.imm_value_in     = imm;
    bus.alu_src_imm_in   = sel;
    bus.dest_reg_in      = rd;
    bus.pc_input         = bus.pc_input + 32'd4;
    bus.reg_write_en_in  = we;
    bus.mem_write_en_in  = 1'b0;
    bus.memory_enable_in = 1'b0;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.src_data_a_in = '0; bus.src_data_b_in = '0; bus.imm_value_in = '0;
    bus.alu_src_imm_in = 1'b0; bus.dest_reg_in = '0; bus.pc_input = 32'h1000;
    bus.ex_control_in = '0; bus.reg_write_en_in = 1'b0;
    bus.mem_write_en_in = 1'b0; bus.memory_enable_in = 1'b0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_reset_valid", 32'(bus.out_valid), 32'd0);
    chk("lit_reset_ready", 32'(bus.in_ready), 32'd1);
    step();

    // ADD overflow wraps
    drive(4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lit_add_valid", 32'(bus.out_valid), 32'd1);
    chk("lit_add_res", bus.alu_result_out, 32'h8000_0000);
    chk("lit_add_store", bus.store_data_out, 32'd1);
    step();

    // Back-to-back SUB then SRA with immediate
    drive(4'd1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd6, 1'b1);
    step();
    drive(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd7, 1'b1);
    @(negedge clk);
    chk("lit_sub_res", bus.alu_result_out, 32'hFFFF_FFFE);
    chk("lit_b2b_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lit_sra_res", bus.alu_result_out, 32'hF800_0000);
    step();

    // MUL latency and result
    drive(4'd11, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 5'd8, 1'b1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      chk("lit_mul_busy", 32'(bus.busy), 32'd1);
      chk("lit_mul_noready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("lit_mul_valid", 32'(bus.out_valid), 32'd1);
    chk("lit_mul_res", bus.alu_result_out, 32'hFFFF_FFFD);
    step();

    // Backpressure holds the slot; pending bundle enters when released
    drive(4'd0, 32'd8, 32'd8, 32'd0, 1'b0, 5'd9, 1'b1);
    step();
    bus.out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_hold_res", bus.alu_result_out, 32'h10);
      chk("lit_hold_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("lit_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lit_release_res", bus.alu_result_out, 32'd3);
    chk("lit_release_valid", 32'(bus.out_valid), 32'd1);
    step();

    // Flush mid-multiply
    drive(4'd11, 32'd5, 32'd6, 32'd0, 1'b0, 5'd11, 1'b1);
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("lit_flush_busy", 32'(bus.busy), 32'd0);
    chk("lit_flush_valid", 32'(bus.out_valid), 32'd0);
    repeat (30) step();
    @(negedge clk);
    chk("lit_flush_noresult", 32'(bus.out_valid), 32'd0);
    step();
    drive(4'd0, 32'd2, 32'd2, 32'd0, 1'b0, 5'd12, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lit_after_flush", bus.alu_result_out, 32'd4);
    step();

    // Asynchronous reset mid-multiply
    drive(4'd11, 32'd7, 32'd7, 32'd0, 1'b0, 5'd13, 1'b1);
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_busy", 32'(bus.busy), 32'd0);
    chk("lit_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("lit_rst_res", bus.alu_result_out, 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();

    // x0 destination suppresses writeback
    drive(4'd0, 32'd9, 32'd1, 32'd0, 1'b0, 5'd0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lit_x0_we", 32'(bus.reg_write_en_out), 32'd0);
    chk("lit_x0_res", bus.alu_result_out, 32'd10);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 7) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
      drive(op, rnd32(), rnd32(), rnd32(), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      bus.in_valid         = ($urandom_range(0, 9) < 6);
      bus.mem_write_en_in  = 1'($urandom_range(0, 1));
      bus.memory_enable_in = 1'($urandom_range(0, 1));
      bus.out_ready        = ($urandom_range(0, 9) < 7);
      flush                = ($urandom_range(0, 39) == 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    flush = 1'b0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
